// File: rtl/dec_num_entry_pkg.sv
// Shared definitions for the decimal keypad-entry accumulator:
// FSM state encoding and the largest legal BCD digit.
package dec_num_entry_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    ENTRY = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/dec_digit_acc.sv
// Combinational digit accumulate step: cand = mag*10 + digit, plus a range
// check against the sign-dependent magnitude limit.
module dec_digit_acc
  import dec_num_entry_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] mag,
  input  logic [3:0]       digit,
  input  logic             neg,
  output logic [WIDTH+3:0] cand,
  output logic             ok
);

  logic [WIDTH+3:0] mag_ext;
  logic [WIDTH+3:0] lim;
  logic [WIDTH+3:0] lim_pos;
  logic [WIDTH+3:0] lim_neg;

  // Four extra bits hold mag*10+9 for any WIDTH-bit mag, so the compare sees the full value.
  assign mag_ext = {4'b0000, mag};
  assign cand    = (mag_ext << 3) + (mag_ext << 1) + {{WIDTH{1'b0}}, digit};

  assign lim_pos = {5'b00000, {(WIDTH-1){1'b1}}};
  assign lim_neg = {4'b0000, 1'b1, {(WIDTH-1){1'b0}}};
  assign lim     = neg ? lim_neg : lim_pos;

  assign ok = (digit <= BCD_MAX) && (cand <= lim);

endmodule

// File: rtl/dec_num_entry.sv
// Decimal keypad-entry accumulator: builds a signed WIDTH-bit value from digit,
// sign, clear and enter strobes; commits it to result on enter.
module dec_num_entry
  import dec_num_entry_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             digit_stb,
  input  logic [3:0]       digit,
  input  logic             neg_stb,
  input  logic             clear_stb,
  input  logic             enter_stb,
  output logic [WIDTH-1:0] value,
  output logic             neg,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             reject
);

  localparam logic [WIDTH-1:0] MAG_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mag, mag_nxt;
  logic             neg_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             done_nxt;
  logic             reject_nxt;
  logic [WIDTH+3:0] cand;
  logic             ok;

  dec_digit_acc #(.WIDTH(WIDTH)) u_acc (
    .mag   (mag),
    .digit (digit),
    .neg   (neg),
    .cand  (cand),
    .ok    (ok)
  );

  // Priority decode: clear > enter > neg > digit; lower strobes are dropped silently.
  always_comb begin
    state_nxt  = state;
    mag_nxt    = mag;
    neg_nxt    = neg;
    result_nxt = result;
    done_nxt   = 1'b0;
    reject_nxt = 1'b0;
    if (clear_stb) begin
      mag_nxt   = '0;
      neg_nxt   = 1'b0;
      state_nxt = EMPTY;
    end else if (enter_stb) begin
      result_nxt = value;
      done_nxt   = 1'b1;
      mag_nxt    = '0;
      neg_nxt    = 1'b0;
      state_nxt  = EMPTY;
    end else if (neg_stb) begin
      if (neg && (mag == MAG_MIN_NEG)) begin
        reject_nxt = 1'b1;
      end else begin
        neg_nxt = ~neg;
      end
    end else if (digit_stb) begin
      if (ok) begin
        mag_nxt = cand[WIDTH-1:0];
        if (cand != '0) begin
          state_nxt = ENTRY;
        end
      end else begin
        reject_nxt = 1'b1;
      end
    end
  end

  // value is registered from the next-state magnitude/sign so it lines up with neg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      mag    <= '0;
      neg    <= 1'b0;
      value  <= '0;
      result <= '0;
      done   <= 1'b0;
      reject <= 1'b0;
    end else begin
      state  <= state_nxt;
      mag    <= mag_nxt;
      neg    <= neg_nxt;
      value  <= neg_nxt ? (~mag_nxt + 1'b1) : mag_nxt;
      result <= result_nxt;
      done   <= done_nxt;
      reject <= reject_nxt;
    end
  end

endmodule

// File: tb/tb_dec_num_entry.sv
// Directed bench for dec_num_entry: expected outputs are queued as each strobe
// is driven and compared one cycle later on the falling edge.
module tb_dec_num_entry;
  import dec_num_entry_pkg::*;

  typedef struct packed {
    logic [7:0] value;
    logic       neg;
    logic [7:0] result;
    logic       done;
    logic       reject;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       digit_stb = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       neg_stb = 1'b0;
  logic       clear_stb = 1'b0;
  logic       enter_stb = 1'b0;
  logic [7:0] value;
  logic       neg;
  logic [7:0] result;
  logic       done;
  logic       reject;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  dec_num_entry #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit_stb (digit_stb),
    .digit     (digit),
    .neg_stb   (neg_stb),
    .clear_stb (clear_stb),
    .enter_stb (enter_stb),
    .value     (value),
    .neg       (neg),
    .result    (result),
    .done      (done),
    .reject    (reject)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of strobes, queue the expectation, compare on the next falling edge.
  task automatic step(input string tag, input logic ds, input logic [3:0] d, input logic ns,
                      input logic cs, input logic es, input logic [7:0] ev, input logic en,
                      input logic [7:0] er, input logic ed, input logic ej);
    exp_t e;
    digit_stb = ds;
    digit     = d;
    neg_stb   = ns;
    clear_stb = cs;
    enter_stb = es;
    sb.push_back('{value: ev, neg: en, result: er, done: ed, reject: ej});
    @(negedge clk);
    digit_stb = 1'b0;
    neg_stb   = 1'b0;
    clear_stb = 1'b0;
    enter_stb = 1'b0;
    e = sb.pop_front();
    check({tag, ".value"},  value,          e.value);
    check({tag, ".neg"},    {7'b0, neg},    {7'b0, e.neg});
    check({tag, ".result"}, result,         e.result);
    check({tag, ".done"},   {7'b0, done},   {7'b0, e.done});
    check({tag, ".reject"}, {7'b0, reject}, {7'b0, e.reject});
  endtask

  initial begin
    // Reset state
    #12;
    check("rst.value",  value,          8'h00);
    check("rst.neg",    {7'b0, neg},    8'h00);
    check("rst.result", result,         8'h00);
    check("rst.done",   {7'b0, done},   8'h00);
    check("rst.reject", {7'b0, reject}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Enter in EMPTY commits 0
    step("enter_empty", 0, 4'd0, 0, 0, 1, 8'h00, 0, 8'h00, 1, 0);

    // 1, 2, 7, enter -> 127
    step("pos_d1",  1, 4'd1, 0, 0, 0, 8'h01, 0, 8'h00, 0, 0);
    step("pos_d2",  1, 4'd2, 0, 0, 0, 8'h0C, 0, 8'h00, 0, 0);
    step("pos_d7",  1, 4'd7, 0, 0, 0, 8'h7F, 0, 8'h00, 0, 0);
    step("pos_ent", 0, 4'd0, 0, 0, 1, 8'h00, 0, 8'h7F, 1, 0);
    step("pos_idle",0, 4'd0, 0, 0, 0, 8'h00, 0, 8'h7F, 0, 0);

    // neg, 1, 2, 8, enter -> -128
    step("neg_s",   0, 4'd0, 1, 0, 0, 8'h00, 1, 8'h7F, 0, 0);
    step("neg_d1",  1, 4'd1, 0, 0, 0, 8'hFF, 1, 8'h7F, 0, 0);
    step("neg_d2",  1, 4'd2, 0, 0, 0, 8'hF4, 1, 8'h7F, 0, 0);
    step("neg_d8",  1, 4'd8, 0, 0, 0, 8'h80, 1, 8'h7F, 0, 0);
    step("neg_ent", 0, 4'd0, 0, 0, 1, 8'h00, 0, 8'h80, 1, 0);

    // Positive 128 is out of range
    step("ovf_d1",  1, 4'd1, 0, 0, 0, 8'h01, 0, 8'h80, 0, 0);
    step("ovf_d2",  1, 4'd2, 0, 0, 0, 8'h0C, 0, 8'h80, 0, 0);
    step("ovf_d8",  1, 4'd8, 0, 0, 0, 8'h0C, 0, 8'h80, 0, 1);
    step("ovf_idle",0, 4'd0, 0, 0, 0, 8'h0C, 0, 8'h80, 0, 0);
    step("ovf_clr", 0, 4'd0, 0, 1, 0, 8'h00, 0, 8'h80, 0, 0);

    // -128 cannot be negated; illegal digit refused
    step("tg_s",    0, 4'd0, 1, 0, 0, 8'h00, 1, 8'h80, 0, 0);
    step("tg_d1",   1, 4'd1, 0, 0, 0, 8'hFF, 1, 8'h80, 0, 0);
    step("tg_d2",   1, 4'd2, 0, 0, 0, 8'hF4, 1, 8'h80, 0, 0);
    step("tg_d8",   1, 4'd8, 0, 0, 0, 8'h80, 1, 8'h80, 0, 0);
    step("tg_neg",  0, 4'd0, 1, 0, 0, 8'h80, 1, 8'h80, 0, 1);
    step("tg_dA",   1, 4'hA, 0, 0, 0, 8'h80, 1, 8'h80, 0, 1);
    step("tg_clr",  0, 4'd0, 0, 1, 0, 8'h00, 0, 8'h80, 0, 0);

    // Illegal digit in EMPTY, sign toggled twice, leading zero keeps EMPTY
    step("e_dF",    1, 4'hF, 0, 0, 0, 8'h00, 0, 8'h80, 0, 1);
    step("e_neg1",  0, 4'd0, 1, 0, 0, 8'h00, 1, 8'h80, 0, 0);
    step("e_neg0",  0, 4'd0, 1, 0, 0, 8'h00, 0, 8'h80, 0, 0);
    step("e_d0",    1, 4'd0, 0, 0, 0, 8'h00, 0, 8'h80, 0, 0);
    check("e_d0.state", 8'(dut.state), 8'(EMPTY));
    step("e_d5",    1, 4'd5, 0, 0, 0, 8'h05, 0, 8'h80, 0, 0);
    check("e_d5.state", 8'(dut.state), 8'(ENTRY));
    step("e_clr",   0, 4'd0, 0, 1, 0, 8'h00, 0, 8'h80, 0, 0);

    // Priority: clear beats digit; enter beats neg and digit
    step("pr_d4",   1, 4'd4, 0, 0, 0, 8'h04, 0, 8'h80, 0, 0);
    step("pr_d2",   1, 4'd2, 0, 0, 0, 8'h2A, 0, 8'h80, 0, 0);
    step("pr_clr",  1, 4'd5, 0, 1, 0, 8'h00, 0, 8'h80, 0, 0);
    step("pr_d3",   1, 4'd3, 0, 0, 0, 8'h03, 0, 8'h80, 0, 0);
    step("pr_ent",  1, 4'hA, 1, 0, 1, 8'h00, 0, 8'h03, 1, 0);

    // Asynchronous reset mid-entry
    step("ar_d4",   1, 4'd4, 0, 0, 0, 8'h04, 0, 8'h03, 0, 0);
    step("ar_d2",   1, 4'd2, 0, 0, 0, 8'h2A, 0, 8'h03, 0, 0);
    check("ar_pre.state", 8'(dut.state), 8'(ENTRY));
    #1 rst_n = 1'b0;
    #1;
    check("ar.value",  value,        8'h00);
    check("ar.neg",    {7'b0, neg},  8'h00);
    check("ar.result", result,       8'h00);
    check("ar.done",   {7'b0, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_post.state", 8'(dut.state), 8'(EMPTY));
    step("ar_d9",   1, 4'd9, 0, 0, 0, 8'h09, 0, 8'h00, 0, 0);

    check("sb.empty", 8'(sb.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
